// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the single-port data memory between the pipeline MEM
//            stage (CPU) and an external host port. The CPU has priority.
//            The host runs fixed-length bursts. A starvation guard
//            force-grants the host after STARVE_LIMIT contended idle cycles.
//            Every burst is followed by one GAP cycle, which leaves the CPU
//            an unstalled slot.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            cpu_*_i / cpu_*_o   - MEM-stage request, store data, load data, stall
//            host_*_i / host_*_o - burst request, per-beat data, read data,
//                                  beat strobe and done pulse
//            mem_*_o / mem_*_i   - DATA_MEM write enable, address, write data,
//                                  read data (combinational read)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int LW           = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [LW-1:0] host_len_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_beat_o,
  output logic [DW-1:0] host_rdata_o,
  output logic          host_rvalid_o,
  output logic          host_done_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q,  state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] beat_q,   beat_d;
  logic [LW-1:0] len_q,    len_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic          we_q,     we_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          done_q,   done_d;
  logic          grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    beat_d      = beat_q;
    len_d       = len_q;
    addr_d      = addr_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    grant       = 1'b0;
    // The CPU owns the memory outside HOST. The write enable is gated with
    // reset so that no store can reach memory while the block is held in reset.
    mem_we_o    = cpu_req_i & cpu_we_i & rst_n;
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    cpu_stall_o = 1'b0;
    host_beat_o = 1'b0;

    case (state_q)
      IDLE: begin
        grant = host_req_i & (~cpu_req_i | (starve_q == STARVE_MAX));
        if (grant) begin
          // The CPU access in this cycle is still served by the default mux.
          state_d  = HOST;
          starve_d = '0;
          beat_d   = '0;
          len_d    = host_len_i;
          addr_d   = host_addr_i;
          we_d     = host_we_i;
        end else if (!host_req_i) begin
          starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
          // A pending host request without a grant means the CPU is contending.
          starve_d = starve_q + 1'b1;
        end
      end

      HOST: begin
        host_beat_o = 1'b1;
        cpu_stall_o = cpu_req_i;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q + AW'(beat_q);   // wraps modulo 2^AW
        mem_wdata_o = host_wdata_i;
        rvalid_d    = ~we_q;
        if (!we_q) begin
          rdata_d = mem_rdata_i;
        end
        if (beat_q == len_q) begin
          state_d = GAP;
          done_d  = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      GAP: begin
        // host_req_i is deliberately not looked at here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rdata_o   = mem_rdata_i;
  assign host_rdata_o  = rdata_q;
  assign host_rvalid_o = rvalid_q;
  assign host_done_o   = done_q;

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU) and an external host port used for program/data loading and debug readback.
- Sits between MEM_REG outputs and DATA_MEM.
- CPU has priority. The host runs fixed-length bursts; a starvation guard guarantees host progress. A forced CPU gap slot follows every burst.
- Drives a stall to the hazard logic while the host owns the port.

Parameters:
AW, 5, memory word-address width (matches the 5-bit DATA_MEM address)
DW, 32, data width
LW, 3, burst-length field width (max burst = 2^LW beats)
STARVE_LIMIT, 4, contended IDLE cycles before the host is force-granted

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
cpu_req  in  1  MEM stage has a valid load or store this cycle
cpu_we  in  1  CPU store
cpu_addr  in  AW  CPU address (ALUResultM[4:0])
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  CPU load data, combinational from mem_rdata
cpu_stall  out  1  freeze PC/D/E/M pipeline registers
host_req  in  1  burst request, level, sampled only in IDLE
host_we  in  1  burst is write (1) or read (0), sampled with host_req
host_addr  in  AW  burst start address, sampled with host_req
host_len  in  LW  beats minus 1, sampled with host_req
host_wdata  in  DW  write data for the current beat
host_beat  out  1  current beat issued to memory; host presents next wdata after this edge
host_rdata  out  DW  registered read data
host_rvalid  out  1  host_rdata valid, 1 cycle after the read beat
host_done  out  1  single-cycle pulse after the last beat
mem_we  out  1  to DATA_MEM WE
mem_addr  out  AW  to DATA_MEM A
mem_wdata  out  DW  to DATA_MEM WD
mem_rdata  in  DW  from DATA_MEM RD (combinational read)

Behaviour:
- FSM states: IDLE, HOST, GAP. Reset (RST=0, async) forces IDLE.
- On reset, all counters and latched host fields clear. host_rdata=0, host_rvalid=0, host_done=0, mem_we=0, and cpu_stall=0 while in reset.
- Memory mux:
  - IDLE and GAP: mem_* = cpu_*, and mem_we = cpu_req & cpu_we.
  - HOST: mem_addr = start + beat_cnt (mod 2^AW, wraps 31->0). mem_we = latched we. mem_wdata = host_wdata.
- cpu_stall = cpu_req & (state==HOST). It is combinational, with no stall in IDLE or GAP.
- Grant in IDLE: the host is granted when host_req & (!cpu_req | starve_cnt==STARVE_LIMIT).
  - On grant: latch we/addr/len, clear beat_cnt, next state HOST.
  - The CPU access in the grant cycle is still served.
- starve_cnt:
  - Increments in each IDLE cycle with host_req & cpu_req and no grant; it saturates at STARVE_LIMIT.
  - It clears on grant or when host_req=0.
- HOST:
  - One beat per cycle, with host_beat=1.
  - beat_cnt increments; when beat_cnt==len, next state GAP.
  - host_req changes are ignored mid-burst; a burst always completes.
- Read beats: host_rdata <= mem_rdata and host_rvalid <= 1 on the same edge. On write beats host_rvalid <= 0.
- GAP: exactly one cycle, host_done=1 (registered, asserted the cycle after the last beat), then IDLE.
  - host_req is ignored in GAP, which guarantees the CPU one unstalled slot.
- host_len=0 gives a 1-beat burst. A full-length burst (len=2^LW-1) gives 2^LW beats.
- A reset mid-burst aborts the burst with no host_done, and the next burst restarts from IDLE.

Test Plan:
- Reset: hold RST=0 with random inputs -> host_rvalid=0, host_done=0, mem_we=0; after release the FSM is in IDLE and CPU stores pass through to mem_* in the same cycle.
- Write burst, host_addr=30, host_len=3, cpu_req=0 -> grant cycle, then 4 HOST cycles with mem_addr 30,31,0,1, mem_we=1, host_beat=1; then GAP with host_done=1; then IDLE.
- Read burst len=1 at addr 4, with memory preloaded [4]=0xAAAA5555, [5]=0x12345678 -> host_rvalid high for 2 cycles with host_rdata 0xAAAA5555 then 0x12345678, each 1 cycle after its beat.
- Contention, STARVE_LIMIT=4, cpu_req=1 constantly, host_req raised at cycle 0 -> starve_cnt 0..4, grant on cycle 4, HOST from cycle 5 with cpu_stall=1 for len+1 cycles; GAP shows cpu_stall=0 and no re-grant even though host_req stays high.
- Stall interaction: CPU store to addr 7 pending during a len=2 host burst -> the store is held (cpu_stall=1) and written in the GAP cycle; memory [7] holds the CPU data, not host data.
- Reset mid-burst: assert RST=0 on the 2nd beat of a len=3 burst -> immediate IDLE, no host_done, and beats 3-4 are not written.
